// File: rtl/inv_key_schedule.sv
// Iterative AES-128 inverse key schedule: loaded with round key 10, emits
// round keys 10..0 one per out_valid/out_ready handshake, one S-box level per cycle.

module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:2047] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = TBL[{a, 3'b000} +: 8];
endmodule

module inv_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [0:127] key_in,
  input  logic         out_ready,
  output logic [0:127] key_out,
  output logic [3:0]   round,
  output logic         out_valid,
  output logic         busy,
  output logic         done
);
  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state_q, state_d;
  logic [0:127] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;

  logic [0:31]  w0, w1, w2, w3, p0, p1, p2, p3, rot, sub;
  logic [7:0]   rcon;

  assign w0 = key_q[0:31];
  assign w1 = key_q[32:63];
  assign w2 = key_q[64:95];
  assign w3 = key_q[96:127];

  assign p3  = w3 ^ w2;
  assign p2  = w2 ^ w1;
  assign p1  = w1 ^ w0;
  assign rot = {p3[8:31], p3[0:7]};

  for (genvar i = 0; i < 4; i++) begin : g_sb
    sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
  end

  // rcon is indexed by the round being undone; rcon[0] never reaches key_d
  always_comb begin
    rcon = 8'h00;
    case (round_q)
      4'd1:  rcon = 8'h01;
      4'd2:  rcon = 8'h02;
      4'd3:  rcon = 8'h04;
      4'd4:  rcon = 8'h08;
      4'd5:  rcon = 8'h10;
      4'd6:  rcon = 8'h20;
      4'd7:  rcon = 8'h40;
      4'd8:  rcon = 8'h80;
      4'd9:  rcon = 8'h1b;
      4'd10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign p0 = w0 ^ sub ^ {rcon, 24'h000000};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = EMIT;
        key_d   = key_in;
        round_d = 4'd10;
      end
      EMIT: if (out_ready) begin
        if (round_q == 4'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          key_d   = {p0, p1, p2, p3};
          round_d = round_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign key_out   = key_q;
  assign round     = round_q;
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign done      = done_q;
endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule using the FIPS-197 A.1 round keys.
module tb_inv_key_schedule;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         out_ready;
  logic [127:0] key_out;
  logic [3:0]   round;
  logic         out_valid, busy, done;

  int nchk = 0;
  int nerr = 0;
  logic [15:0] lfsr = 16'hace1;

  localparam logic [127:0] ZK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  logic [127:0] fips [0:10];

  inv_key_schedule dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .out_ready(out_ready),
    .key_out(key_out), .round(round), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".key"},   key_out,          128'h0);
    check({tag, ".round"}, 128'(round),      128'h0);
    check({tag, ".vld"},   128'(out_valid),  128'h0);
    check({tag, ".busy"},  128'(busy),       128'h0);
    check({tag, ".done"},  128'(done),       128'h0);
  endtask

  function automatic bit next_rdy();
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    return lfsr[0];
  endfunction

  // Called at the negedge after start was sampled. Walks the sequence,
  // checking every cycle (stalls included); returns at the done cycle.
  task automatic run_seq(input string tag, input bit bp, input bit full,
                         input logic [127:0] k10, input logic [127:0] k0, input int inj);
    int  r   = 10;
    bit  fin = 1'b0;
    bit  injd = 1'b0;
    for (int n = 0; n < 400 && !fin; n++) begin
      start = 1'b0;
      if (r < 0) begin
        check({tag, ".done"},     128'(done),      128'h1);
        check({tag, ".done_vld"}, 128'(out_valid), 128'h0);
        check({tag, ".done_bsy"}, 128'(busy),      128'h0);
        out_ready = 1'b0;
        fin = 1'b1;
      end else begin
        check({tag, ".vld"},   128'(out_valid), 128'h1);
        check({tag, ".busy"},  128'(busy),      128'h1);
        check({tag, ".nodn"},  128'(done),      128'h0);
        check({tag, ".round"}, 128'(round),     128'(r));
        if (r == 10)     check({tag, ".k10"}, key_out, k10);
        else if (r == 0) check({tag, ".k0"},  key_out, k0);
        else if (full)   check({tag, ".key"}, key_out, fips[r]);
        if (inj >= 0 && r == inj && !injd) begin
          start  = 1'b1;
          key_in = ZK10;
          injd   = 1'b1;
        end
        out_ready = bp ? next_rdy() : 1'b1;
        if (out_ready) r--;
        @(negedge clk);
      end
    end
    if (!fin) check({tag, ".timeout"}, 128'h0, 128'h1);
  endtask

  task automatic load(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    @(negedge clk);
  endtask

  initial begin
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst = 1'b1; start = 1'b1; key_in = fips[10]; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_idle("idle_rdy");

    load(fips[10]);
    run_seq("fips", 1'b0, 1'b1, fips[10], fips[0], -1);
    @(negedge clk);
    check("fips.pulse", 128'(done), 128'h0);

    load(fips[10]);
    run_seq("bp", 1'b1, 1'b1, fips[10], fips[0], -1);
    @(negedge clk);

    load(fips[10]);
    run_seq("ign", 1'b0, 1'b1, fips[10], fips[0], 5);

    // start in the done cycle is accepted
    load(ZK10);
    run_seq("b2b", 1'b0, 1'b0, ZK10, 128'h0, -1);
    @(negedge clk);

    load(fips[10]);
    start = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && round != 4'd6; n++) @(negedge clk);
    check("rst.at6", 128'(round), 128'h6);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check_idle("rst.mid");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_idle("rst.after");
    load(fips[10]);
    run_seq("rerun", 1'b0, 1'b1, fips[10], fips[0], -1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
